// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: receive FSM state encoding and bit-timing helpers
// used by both the receiver and the transmitter.
package uart_receiver_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    localparam int unsigned UartDataBits = 8;

    // Clock cycles per bit on the line.
    function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                     input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Offset from the start-bit edge to the middle of the start bit.
    function automatic int unsigned sample_time(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_receiver_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to 1 so an idle
// UART line is not mistaken for a start bit while coming out of reset.
module uart_receiver_sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a valid/ready byte output. Define UART_RX_FRAMING_ERR_EN
// to expose a one-cycle framing_error pulse for frames with a bad stop bit.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 33_000_000,
    parameter int unsigned BAUD_RATE  = 115_200
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    serial_in,
    output logic [UartDataBits-1:0] data_out,
    output logic                    data_out_valid,
    input  logic                    data_out_ready
`ifdef UART_RX_FRAMING_ERR_EN
    ,
    output logic                    framing_error
`endif
);

    localparam int unsigned SymbolEdgeTime = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned SampleTime     = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CntW           = $clog2(SymbolEdgeTime);
    localparam int unsigned IdxW           = $clog2(UartDataBits);

    localparam logic [CntW-1:0] SampleLast = CntW'(SampleTime - 1);
    localparam logic [CntW-1:0] SymbolLast = CntW'(SymbolEdgeTime - 1);
    localparam logic [IdxW-1:0] LastBit    = IdxW'(UartDataBits - 1);

    logic                    rx_s;
    uart_state_e             state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [IdxW-1:0]         bit_idx_q, bit_idx_d;
    logic [UartDataBits-1:0] shift_q, shift_d;
    logic [UartDataBits-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    byte_done;
    logic                    frame_bad;

    uart_receiver_sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (serial_in),
        .dout  (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_bad = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == SampleLast) begin
                    cnt_d = '0;
                    // Line back high by mid start bit: treat as a glitch.
                    if (rx_s) begin
                        state_d = StIdle;
                    end else begin
                        state_d   = StData;
                        bit_idx_d = '0;
                    end
                end
            end
            StData: begin
                if (cnt_q == SymbolLast) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[UartDataBits-1:1]};
                    bit_idx_d = bit_idx_q + IdxW'(1);
                    if (bit_idx_q == LastBit) begin
                        state_d = StStop;
                    end
                end
            end
            StStop: begin
                if (cnt_q == SymbolLast) begin
                    // Leave mid stop bit so a following start edge is not missed.
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (rx_s) begin
                        byte_done = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A held byte is never overwritten unless it is consumed in the same cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (valid_q && data_out_ready) begin
            valid_d = 1'b0;
        end
        if (byte_done && (!valid_q || data_out_ready)) begin
            valid_d = 1'b1;
            data_d  = shift_q;
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;

`ifdef UART_RX_FRAMING_ERR_EN
    logic fe_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fe_q <= 1'b0;
        end else begin
            fe_q <= frame_bad;
        end
    end

    assign framing_error = fe_q;
`else
    logic unused_frame_bad;
    assign unused_frame_bad = frame_bad;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: reference 8N1 transmitter, frame-level timing model
// and a per-cycle compare of data_out/data_out_valid(/framing_error).
module tb_uart_receiver;

    localparam int unsigned Sym = 286;
    // Sync (2) + idle detect (1) + half bit + 9 full bits to the stop sample.
    localparam int unsigned DoneLat = 3 + Sym / 2 + 9 * Sym;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_in = 1'b1;
    logic       data_out_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_out_valid;
`ifdef UART_RX_FRAMING_ERR_EN
    logic       framing_error;
`endif

    always #5 clk = ~clk;

    uart_receiver #(
        .CLOCK_FREQ (33_000_000),
        .BAUD_RATE  (115_200)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
`ifdef UART_RX_FRAMING_ERR_EN
        ,
        .framing_error  (framing_error)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    logic        rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: each frame completes DoneLat edges after its start edge.
    typedef struct {
        int unsigned done;
        logic [7:0]  b;
        logic        good;
    } pend_t;

    pend_t      pend[$];
    logic       m_valid = 1'b0;
    logic       m_fe = 1'b0;
    logic [7:0] m_data = 8'h00;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_fe    <= 1'b0;
            pend.delete();
        end else begin : model
            logic       v;
            logic       fe;
            logic [7:0] d;
            v  = m_valid;
            d  = m_data;
            fe = 1'b0;
            if (m_valid && data_out_ready) v = 1'b0;
            if (pend.size() > 0 && pend[0].done == cyc + 1) begin
                if (pend[0].good) begin
                    if (!m_valid || data_out_ready) begin
                        v = 1'b1;
                        d = pend[0].b;
                    end
                end else begin
                    fe = 1'b1;
                end
                void'(pend.pop_front());
            end
            m_valid <= v;
            m_data  <= d;
            m_fe    <= fe;
        end
    end

    logic [7:0]  got[$];
    logic        prev_valid = 1'b0;
    int unsigned rise_cyc = 0;
    int          valid_hi = 0;
    int          m_fe_hi = 0;
    int          fe_hi = 0;

    always @(negedge clk) begin
        checks++;
        if (data_out_valid !== m_valid) begin
            errors++;
            $display("FAIL valid @%0d: got %b expected %b", cyc, data_out_valid, m_valid);
        end
        checks++;
        if (data_out !== m_data) begin
            errors++;
            $display("FAIL data_out @%0d: got %h expected %h", cyc, data_out, m_data);
        end
`ifdef UART_RX_FRAMING_ERR_EN
        checks++;
        if (framing_error !== m_fe) begin
            errors++;
            $display("FAIL framing_error @%0d: got %b expected %b", cyc, framing_error, m_fe);
        end
        if (framing_error === 1'b1) fe_hi++;
`endif
        if (m_fe) m_fe_hi++;
        if (data_out_valid === 1'b1) valid_hi++;
        if (data_out_valid === 1'b1 && data_out_ready) got.push_back(data_out);
        if (data_out_valid === 1'b1 && !prev_valid) rise_cyc = cyc;
        prev_valid = data_out_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cycles(input int k);
        repeat (k) begin
            @(posedge clk);
            if (rand_ready) begin
                #1;
                data_out_ready = 1'($urandom_range(0, 1));
            end
        end
    endtask

    // Called at a posedge; line stays at the stop value when the task returns.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned n);
        pend_t p;
        #1 serial_in = 1'b0;
        n = cyc;
        p.done = n + DoneLat;
        p.b    = b;
        p.good = stop;
        pend.push_back(p);
        wait_cycles(Sym);
        for (int i = 0; i < 8; i++) begin
            #1 serial_in = b[i];
            wait_cycles(Sym);
        end
        #1 serial_in = stop;
        wait_cycles(Sym);
    endtask

    task automatic idle(input int k);
        #1 serial_in = 1'b1;
        wait_cycles(k);
    endtask

    initial begin
        int unsigned n;
        int          base;
        int          fe0;
        int          mfe0;
        logic [7:0]  pat;

        repeat (3) @(posedge clk);
        #1;
        check("reset_data_out", 32'(data_out), 32'h00);
        check("reset_valid", 32'(data_out_valid), 32'h0);
        reset = 1'b1;
        @(posedge clk);

        // Single frame, ready held high.
        #1 data_out_ready = 1'b1;
        base = got.size();
        valid_hi = 0;
        send_frame(8'hA5, 1'b1, n);
        idle(20);
        check("a5_count", 32'(got.size() - base), 32'd1);
        if (got.size() > base) check("a5_data", 32'(got[base]), 32'hA5);
        check("a5_latency", rise_cyc - n, 32'd2720);
        check("a5_valid_cycles", 32'(valid_hi), 32'd1);

        // Back-to-back frames, no idle gap.
        base = got.size();
        send_frame(8'h00, 1'b1, n);
        send_frame(8'hFF, 1'b1, n);
        send_frame(8'h55, 1'b1, n);
        idle(20);
        check("b2b_count", 32'(got.size() - base), 32'd3);
        if (got.size() >= base + 3) begin
            check("b2b_0", 32'(got[base]), 32'h00);
            check("b2b_1", 32'(got[base + 1]), 32'hFF);
            check("b2b_2", 32'(got[base + 2]), 32'h55);
        end

        // Short low glitch on an idle line.
        base = got.size();
        fe0  = fe_hi;
        #1 serial_in = 1'b0;
        wait_cycles(50);
        idle(400);
        check("glitch_count", 32'(got.size() - base), 32'd0);
        check("glitch_fe", 32'(fe_hi - fe0), 32'd0);

        // Overrun: second byte dropped while the first is held.
        #1 data_out_ready = 1'b0;
        base = got.size();
        send_frame(8'h3C, 1'b1, n);
        send_frame(8'hC3, 1'b1, n);
        idle(20);
        check("ovr_valid", 32'(data_out_valid), 32'h1);
        check("ovr_data", 32'(data_out), 32'h3C);
        #1 data_out_ready = 1'b1;
        wait_cycles(5);
        check("ovr_count", 32'(got.size() - base), 32'd1);
        if (got.size() > base) check("ovr_byte", 32'(got[base]), 32'h3C);
        check("ovr_drained", 32'(data_out_valid), 32'h0);

        // Bad stop bit.
        base = got.size();
        fe0  = fe_hi;
        mfe0 = m_fe_hi;
        send_frame(8'h81, 1'b0, n);
        idle(600);
        check("ferr_count", 32'(got.size() - base), 32'd0);
        check("ferr_model_pulse", 32'(m_fe_hi - mfe0), 32'd1);
`ifdef UART_RX_FRAMING_ERR_EN
        check("ferr_pulse", 32'(fe_hi - fe0), 32'd1);
`endif

        // Reset in the middle of the data bits of 0x7E.
        pat = 8'h7E;
        #1 serial_in = 1'b0;
        wait_cycles(Sym);
        for (int i = 0; i < 3; i++) begin
            #1 serial_in = pat[i];
            wait_cycles(Sym);
        end
        wait_cycles(Sym / 3);
        #1;
        reset = 1'b0;
        serial_in = 1'b1;
        wait_cycles(10);
        check("rst_mid_data", 32'(data_out), 32'h00);
        check("rst_mid_valid", 32'(data_out_valid), 32'h0);
        #1 reset = 1'b1;
        base = got.size();
        idle(5);
        send_frame(8'h12, 1'b1, n);
        idle(20);
        check("after_rst_count", 32'(got.size() - base), 32'd1);
        if (got.size() > base) check("after_rst_byte", 32'(got[base]), 32'h12);

        // Random bytes, random ready, occasional bad stop bits.
        rand_ready = 1'b1;
        for (int f = 0; f < 12; f++) begin
            logic [7:0] b;
            logic       good;
            b    = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            send_frame(b, good, n);
            idle(good ? int'($urandom_range(0, 40)) : 600);
        end
        rand_ready = 1'b0;
        #1 data_out_ready = 1'b1;
        wait_cycles(10);
        check("final_drained", 32'(data_out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
